// File: rtl/point_uart_tx.sv
// point_uart_tx: once per video frame, snapshots the tracked point at the
// falling edge of VGA_VS and sends a 6-byte packet (header, H, V, checksum)
// on an 8N1 UART line, LSB first. Triggers arriving while a packet is in
// flight are counted in a saturating drop counter.
module point_uart_tx #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        VGA_VS,
    input  logic        EN,
    input  logic [15:0] POINT_H,
    input  logic [15:0] POINT_V,
    output logic        UART_TX,
    output logic        BUSY,
    output logic [7:0]  DROP_CNT
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // 8-bit sum of the four payload bytes; the carry is discarded.
    function automatic logic [7:0] checksum(input logic [15:0] h, input logic [15:0] v);
        checksum = h[15:8] + h[7:0] + v[15:8] + v[7:0];
    endfunction

    // Packet byte for a given position, taken from the latched coordinates.
    function automatic logic [7:0] packet_byte(input logic [2:0] idx,
                                               input logic [15:0] h,
                                               input logic [15:0] v);
        case (idx)
            3'd0:    packet_byte = HEADER;
            3'd1:    packet_byte = h[15:8];
            3'd2:    packet_byte = h[7:0];
            3'd3:    packet_byte = v[15:8];
            3'd4:    packet_byte = v[7:0];
            3'd5:    packet_byte = checksum(h, v);
            default: packet_byte = 8'hFF;
        endcase
    endfunction

    state_t      state, state_next;
    logic [15:0] baud_cnt, baud_cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [2:0]  byte_idx, byte_idx_next;
    logic [7:0]  shift, shift_next;
    logic [15:0] hold_h, hold_h_next;
    logic [15:0] hold_v, hold_v_next;
    logic [7:0]  drop_next;
    logic        vs_prev;
    logic        tx_next;
    logic        trigger;
    logic        bit_done;

    assign trigger  = vs_prev & ~VGA_VS;
    assign bit_done = (baud_cnt == BAUD_LAST);

    // Next-state, datapath and output decode; outputs are registered from
    // the next-state values so they change on the cycle after the decision.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 16'd1;
        bit_idx_next  = bit_idx;
        byte_idx_next = byte_idx;
        shift_next    = shift;
        hold_h_next   = hold_h;
        hold_v_next   = hold_v;
        drop_next     = DROP_CNT;
        tx_next       = 1'b1;

        case (state)
            ST_IDLE: begin
                baud_cnt_next = 16'd0;
                if (trigger && EN) begin
                    state_next    = ST_START;
                    byte_idx_next = 3'd0;
                    hold_h_next   = POINT_H;
                    hold_v_next   = POINT_V;
                    shift_next    = HEADER;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next    = ST_DATA;
                    baud_cnt_next = 16'd0;
                    bit_idx_next  = 3'd0;
                end else begin
                    state_next = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_cnt_next = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        shift_next   = {1'b0, shift[7:1]};
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    state_next = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    baud_cnt_next = 16'd0;
                    if (byte_idx < 3'd5) begin
                        state_next    = ST_START;
                        byte_idx_next = byte_idx + 3'd1;
                        shift_next    = packet_byte(byte_idx + 3'd1, hold_h, hold_v);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    state_next = ST_STOP;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                baud_cnt_next = 16'd0;
            end
        endcase

        // A trigger while any packet state is active is a dropped frame.
        if (trigger && EN && (state != ST_IDLE) && (DROP_CNT != 8'hFF)) begin
            drop_next = DROP_CNT + 8'd1;
        end else begin
            drop_next = DROP_CNT;
        end

        case (state_next)
            ST_IDLE:  tx_next = 1'b1;
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[0];
            ST_STOP:  tx_next = 1'b1;
            default:  tx_next = 1'b1;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            shift    <= 8'd0;
            hold_h   <= 16'd0;
            hold_v   <= 16'd0;
            vs_prev  <= 1'b0;
            DROP_CNT <= 8'd0;
            UART_TX  <= 1'b1;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            byte_idx <= byte_idx_next;
            shift    <= shift_next;
            hold_h   <= hold_h_next;
            hold_v   <= hold_v_next;
            vs_prev  <= VGA_VS;
            DROP_CNT <= drop_next;
            UART_TX  <= tx_next;
            BUSY     <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_point_uart_tx.sv
// Directed bench for point_uart_tx with CLKS_PER_BIT=4: packets are captured
// bit by bit from UART_TX and compared against hand-computed byte frames.
module tb_point_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        VGA_VS;
    logic        EN;
    logic [15:0] POINT_H;
    logic [15:0] POINT_V;
    logic        UART_TX;
    logic        BUSY;
    logic [7:0]  DROP_CNT;

    int vectors    = 0;
    int miscompares = 0;

    point_uart_tx #(.CLKS_PER_BIT(4), .HEADER(8'hA5)) dut (
        .clk      (clk),
        .reset    (reset),
        .VGA_VS   (VGA_VS),
        .EN       (EN),
        .POINT_H  (POINT_H),
        .POINT_V  (POINT_V),
        .UART_TX  (UART_TX),
        .BUSY     (BUSY),
        .DROP_CNT (DROP_CNT)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Produce a VS falling edge sampled on the next clock; returns one cycle
    // after the trigger cycle.
    task automatic fire();
        VGA_VS = 1'b1;
        tick();
        VGA_VS = 1'b0;
        tick();
    endtask

    // Capture 240 cycles of a packet starting one cycle after the trigger.
    // At i==50 EN and POINT_H are overwritten; at i==vs_low_i VS is pulled low.
    task automatic run_packet(input string tag, input logic [47:0] exp,
                              input logic en_mid, input logic [15:0] h_mid,
                              input int vs_low_i);
        logic       line [0:239];
        int         busy_cycles;
        logic [9:0] frame;
        logic [7:0] eb;
        busy_cycles = 0;
        check({tag, " first start bit"}, {62'd0, UART_TX, BUSY}, 64'h1);
        for (int i = 0; i < 240; i++) begin
            line[i] = UART_TX;
            if (BUSY) busy_cycles++;
            if (i == 5) VGA_VS = 1'b1;
            if (i == 50) begin
                EN      = en_mid;
                POINT_H = h_mid;
            end
            if (i == vs_low_i) VGA_VS = 1'b0;
            tick();
        end
        check({tag, " busy cycles"}, 64'(busy_cycles), 64'd240);
        check({tag, " end idle"}, {62'd0, UART_TX, BUSY}, 64'h2);
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 10; k++) frame[k] = line[j*40 + k*4 + 2];
            eb = exp[47 - 8*j -: 8];
            check($sformatf("%s byte%0d", tag, j), 64'(frame), 64'({1'b1, eb, 1'b0}));
        end
    endtask

    initial begin
        reset   = 1'b1;
        VGA_VS  = 1'b0;
        EN      = 1'b1;
        POINT_H = 16'h0140;
        POINT_V = 16'h00F0;
        tick();
        tick();
        check("reset values", {54'd0, UART_TX, BUSY, DROP_CNT}, {54'd0, 1'b1, 1'b0, 8'h00});
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("no trigger after reset", {62'd0, UART_TX, BUSY}, 64'h2);

        // Basic packet: A5 01 40 00 F0 31.
        fire();
        run_packet("pkt1", 48'hA5_01_40_00_F0_31, 1'b1, 16'h0140, -1);
        check("pkt1 drop", 64'(DROP_CNT), 64'h00);

        // Second VS fall 100 cycles into the packet is dropped.
        fire();
        run_packet("pkt2", 48'hA5_01_40_00_F0_31, 1'b1, 16'h0140, 100);
        check("drop one", 64'(DROP_CNT), 64'h01);

        // All-ones point: checksum FC; H and EN changed mid-packet.
        POINT_H = 16'hFFFF;
        POINT_V = 16'hFFFF;
        fire();
        run_packet("pkt3", 48'hA5_FF_FF_FF_FF_FC, 1'b0, 16'h1234, -1);
        check("pkt3 drop", 64'(DROP_CNT), 64'h01);

        // EN low during VS fall: no packet, no drop.
        fire();
        for (int i = 0; i < 6; i++) tick();
        check("en0 idle", {54'd0, UART_TX, BUSY, DROP_CNT}, {54'd0, 1'b1, 1'b0, 8'h01});

        // Trigger on the cycle BUSY falls is accepted; trigger in final STOP is dropped.
        EN      = 1'b1;
        POINT_H = 16'h0140;
        POINT_V = 16'h00F0;
        fire();
        run_packet("pkt4", 48'hA5_01_40_00_F0_31, 1'b1, 16'h0140, -1);
        VGA_VS = 1'b0;
        tick();
        run_packet("pkt5", 48'hA5_01_40_00_F0_31, 1'b1, 16'h0140, 239);
        check("boundary drops", 64'(DROP_CNT), 64'h02);
        tick();
        check("after stop drop idle", {62'd0, UART_TX, BUSY}, 64'h2);

        // Reset during DATA of byte 2, then a fresh packet.
        fire();
        for (int i = 0; i < 89; i++) tick();
        check("mid byte2 busy", 64'(BUSY), 64'h1);
        reset = 1'b1;
        tick();
        check("reset abort", {54'd0, UART_TX, BUSY, DROP_CNT}, {54'd0, 1'b1, 1'b0, 8'h00});
        reset = 1'b0;
        tick();
        fire();
        run_packet("pkt6", 48'hA5_01_40_00_F0_31, 1'b1, 16'h0140, -1);

        // Many falls while busy saturate the drop counter.
        for (int i = 0; i < 600; i++) begin
            VGA_VS = 1'b1;
            tick();
            VGA_VS = 1'b0;
            tick();
        end
        check("drop saturate", 64'(DROP_CNT), 64'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
